simple_uart_rx: RTL
===================

// Module: simple_uart_rx
// PURPOSE
//  8N1 UART receiver, LSB first, counterpart of simpleUARTtx on the same serial line.
//  Resynchronises the line, rejects start-bit glitches and samples each bit at mid-bit.
//  Presents received bytes in a one-deep holding register with a valid/ack handshake.
//  Sits between the board serial input pin and the byte consumer logic in the clk_24MHz domain.
// PARAMETERS
//  CLK_FREQ  24000000  system clock frequency, Hz
//  BAUD      9600      line rate, bit/s
//  BIT_CYC   CLK_FREQ/BAUD (2500)  localparam, clocks per bit; HALF_CYC = BIT_CYC/2 (1250)
// PORTS
//  clk        in   1  system clock (clk_24MHz domain), rising edge
//  resetn     in   1  asynchronous active-low reset
//  rx         in   1  asynchronous serial line, idle high
//  data       out  8  received byte; stable while valid=1
//  valid      out  1  byte available; held until the byte is acknowledged
//  ack        in   1  consumer takes the byte in any cycle with valid=1
//  busy       out  1  1 while a frame is being received (state != IDLE)
//  frame_err  out  1  1-cycle pulse: stop bit sampled low, byte discarded
//  overrun    out  1  1-cycle pulse: byte completed while holding register full, new byte dropped
// BEHAVIOUR
//  Reset: data=0, valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, sync FFs=1, counters=0.
//   Reset mid-frame aborts the frame; no flags are raised.
//  rx passes through a 2-FF synchroniser (rx_s); all decisions use rx_s (2-cycle latency).
//  Bit counter cnt: width $clog2(BIT_CYC); cleared at every state change and at every bit sample.
//  States:
//   IDLE     : rx_s==0 -> START, cnt=0.
//   START    : at cnt==HALF_CYC-1: rx_s==0 -> DATA, bit_idx=0; rx_s==1 -> IDLE (glitch, no flag).
//   DATA     : at cnt==BIT_CYC-1: shift rx_s in at MSB (shift right), bit_idx+1;
//              after the 8th sample (bit_idx==7) -> STOP.
//   STOP     : at cnt==BIT_CYC-1: rx_s==1 -> deliver byte, IDLE;
//              rx_s==0 -> frame_err pulse, WAIT_HI.
//   WAIT_HI  : stays until rx_s==1 (break/stuck-low line), then IDLE. No new start is detected meanwhile.
//  Sample points: data bit k sampled HALF_CYC + (k+1)*BIT_CYC cycles after start detection, stop at +9.
//  Deliver (cycle after stop sample):
//   valid==0            -> data<=byte, valid<=1.
//   valid==1 & ack==1   -> data<=byte, valid stays 1, no overrun.
//   valid==1 & ack==0   -> data unchanged, overrun pulse.
//  ack with valid==0 is ignored. ack with valid==1 and no delivery -> valid<=0 next cycle.
//  Back-to-back frames: a start edge is accepted the first cycle after returning to IDLE.
//  frame_err and overrun are never both asserted; each lasts exactly one clock.
// STRUCTURE
//  uart_pkg: state encoding (IDLE, START, DATA, STOP, WAIT_HI) and DATA_BITS=8, shared with simpleUARTtx.
//  Sub-module sync2: 2-FF synchroniser, reset value parameter (1 here), async active-low reset.
//  Remainder (FSM, counters, shift register, holding register) in one always block + output assigns.
// TESTING (bench params CLK_FREQ=16, BAUD=1 -> BIT_CYC=16, HALF_CYC=8)
//  1. Send 0x41 8N1, ack tied 0 -> valid rises once, data=0x41, busy low again, no flags.
//  2. rx low for 4 cycles, then high -> busy pulses, returns to IDLE, valid stays 0, no flags.
//  3. Send 0x55 with stop bit 0, rx held low 40 cycles -> frame_err single pulse, valid 0,
//     then 0x42 accepted only after rx returns high.
//  4. Send 0x41, 0x42 back-to-back, ack=0 -> data=0x41, valid=1, overrun pulse at second stop;
//     then ack -> valid=0.
//  5. Send 0x43, 0x44 with ack asserted in the exact delivery cycle of 0x44 -> data=0x44,
//     valid stays 1, overrun=0.
//  6. resetn low in the middle of DATA of 0xA5 -> all outputs at reset values; next frame 0x5A
//     is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver/transmitter state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } uart_state_e;

endpackage

// File: rtl/simple_uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a selectable reset value.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/simple_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, one-deep valid/ack holding register.
module simple_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 24000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = $clog2(BIT_CYC);
  localparam int unsigned IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_state_e          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync2 (
    .clk    (clk),
    .resetn (resetn),
    .d      (rx),
    .q      (w_rx_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // Plain acknowledge; a delivery in the STOP branch below takes precedence.
      if (ack && r_valid) begin
        r_valid <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == CNT_HALF_END) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == CNT_BIT_END) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == IDX_LAST) begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == CNT_BIT_END) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= IDLE;
              // Holding register is free if empty or being drained this very cycle.
              if (!r_valid || ack) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HI;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign busy      = (r_state != IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
